// File: rtl/fproc_arbiter_if.sv
// Bundle of the core-side fproc ports and the backend lookup port.
interface fproc_arbiter_if #(
   parameter int unsigned N_CORES        = 5,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned FPROC_ID_WIDTH = 8
);
   logic [N_CORES-1:0]                core_enable;
   logic [N_CORES*FPROC_ID_WIDTH-1:0] core_id;
   logic [N_CORES*DATA_WIDTH-1:0]     core_data;
   logic [N_CORES-1:0]                core_ready;
   logic                              be_req;
   logic [FPROC_ID_WIDTH-1:0]         be_id;
   logic                              be_valid;
   logic [DATA_WIDTH-1:0]             be_data;
   logic [N_CORES-1:0]                err_overrun;
   logic                              err_timeout;

   // Arbiter side
   modport slave (
      input  core_enable, core_id, be_valid, be_data,
      output core_data, core_ready, be_req, be_id, err_overrun, err_timeout
   );

   // Environment side: cores plus backend
   modport master (
      output core_enable, core_id, be_valid, be_data,
      input  core_data, core_ready, be_req, be_id, err_overrun, err_timeout
   );
endinterface

// File: rtl/fproc_arbiter.sv
// Round-robin arbiter sharing one fproc lookup backend among N_CORES cores.
// One queued request per core, one backend transaction in flight, bounded by
// an optional timeout that completes the transaction with zero data.
module fproc_arbiter #(
   parameter int unsigned N_CORES        = 5,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned FPROC_ID_WIDTH = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             reset,
   fproc_arbiter_if.slave   bus
);

   localparam int unsigned IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CORES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t                      r_state;
   state_t                      w_state_next;
   logic [N_CORES-1:0]          r_pending;
   logic [FPROC_ID_WIDTH-1:0]   r_id [N_CORES];
   logic [IDX_W-1:0]            r_rr_ptr;
   logic [IDX_W-1:0]            r_grant;
   logic [CNT_W-1:0]            r_cnt;

   logic [N_CORES*DATA_WIDTH-1:0] r_core_data;
   logic [N_CORES-1:0]            r_core_ready;
   logic                          r_be_req;
   logic [FPROC_ID_WIDTH-1:0]     r_be_id;
   logic [N_CORES-1:0]            r_err_overrun;
   logic                          r_err_timeout;

   logic [IDX_W-1:0]            w_sel;
   logic                        w_hit;
   int unsigned                 w_scan_idx;
   logic                        w_complete;
   logic                        w_timeout;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and completion decode
   always_comb begin
      w_state_next = r_state;
      w_complete   = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (|r_pending) begin
               w_state_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_state_next = S_WAIT;
         end
         S_WAIT: begin
            // A real response wins over a timeout landing in the same cycle
            if (bus.be_valid) begin
               w_complete   = 1'b1;
               w_state_next = S_IDLE;
            end else if (TO_EN && (r_cnt == TO_LAST)) begin
               w_complete   = 1'b1;
               w_timeout    = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // First pending core at or after rr_ptr, wrapping around
   always_comb begin
      w_sel      = r_rr_ptr;
      w_hit      = 1'b0;
      w_scan_idx = 0;
      for (int unsigned k = 0; k < N_CORES; k++) begin
         w_scan_idx = (32'(r_rr_ptr) + k) % N_CORES;
         if (!w_hit && r_pending[IDX_W'(w_scan_idx)]) begin
            w_sel = IDX_W'(w_scan_idx);
            w_hit = 1'b1;
         end
      end
   end

   // Request queue: one slot per core, overruns flagged sticky
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending     <= '0;
         r_err_overrun <= '0;
         for (int i = 0; i < N_CORES; i++) begin
            r_id[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_CORES; i++) begin
            if (w_complete && (r_grant == IDX_W'(i))) begin
               r_pending[i] <= 1'b0;
            end else if (bus.core_enable[i] && !r_pending[i]) begin
               r_pending[i] <= 1'b1;
               r_id[i]      <= bus.core_id[i*FPROC_ID_WIDTH +: FPROC_ID_WIDTH];
            end
            // Still pending when the enable is sampled, even on the completion cycle
            if (bus.core_enable[i] && r_pending[i]) begin
               r_err_overrun[i] <= 1'b1;
            end
         end
      end
   end

   // Grant, backend issue strobe, round-robin pointer and wait counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_grant  <= '0;
         r_rr_ptr <= '0;
         r_be_req <= 1'b0;
         r_be_id  <= '0;
         r_cnt    <= '0;
      end else begin
         r_be_req <= 1'b0;
         r_be_id  <= '0;
         if ((r_state == S_IDLE) && (|r_pending)) begin
            r_grant  <= w_sel;
            r_be_req <= 1'b1;
            r_be_id  <= r_id[w_sel];
         end
         if (r_state == S_ISSUE) begin
            r_cnt <= '0;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_complete) begin
            r_rr_ptr <= (r_grant == LAST_IDX) ? '0 : r_grant + IDX_W'(1);
         end
      end
   end

   // Completion outputs: result, ready strobe, timeout pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         r_core_data   <= '0;
         r_core_ready  <= '0;
         r_err_timeout <= 1'b0;
      end else begin
         r_core_ready  <= '0;
         r_err_timeout <= 1'b0;
         if (w_complete) begin
            r_err_timeout <= w_timeout;
            for (int i = 0; i < N_CORES; i++) begin
               if (r_grant == IDX_W'(i)) begin
                  r_core_ready[i] <= 1'b1;
                  r_core_data[i*DATA_WIDTH +: DATA_WIDTH] <= w_timeout ? '0 : bus.be_data;
               end
            end
         end
      end
   end

   assign bus.core_data   = r_core_data;
   assign bus.core_ready  = r_core_ready;
   assign bus.be_req      = r_be_req;
   assign bus.be_id       = r_be_id;
   assign bus.err_overrun = r_err_overrun;
   assign bus.err_timeout = r_err_timeout;

endmodule
